ifetch_unit: RTL and testbench

//   Instruction fetch stage that consumes the next-PC stream: holds the architectural PC, issues

---
 rtl/ifetch_unit.sv | 106 ++++++++++
 tb/tb_ifetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: architectural PC, single-outstanding imem fetch,
// PC-tagged instruction FIFO toward decode, redirect/flush handling.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nPC,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] PC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] instPC
);

    localparam int unsigned AW      = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int unsigned CW      = AW + 1;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    logic [31:0]   req_pc;
    logic [31:0]   buf_inst [IBUF_DEPTH];
    logic [31:0]   buf_pc   [IBUF_DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          accept;
    logic          push;
    logic          pop;

    // Request is combinational so an accepted fetch costs no extra cycle.
    assign imemReq   = !rst && (state == IDLE) && !redirect && (count < CW'(IBUF_DEPTH));
    assign imemAddr  = PC;
    assign accept    = imemReq && imemReady;
    assign push      = !redirect && (state == WAIT) && imemRvalid;
    assign pop       = instValid && !stall && !redirect;
    assign instValid = (count != '0);
    assign inst      = instValid ? buf_inst[head] : '0;
    assign instPC    = instValid ? buf_pc[head]   : '0;

    // Fetch FSM and PC; redirect overrides everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            PC     <= RESET_PC & PC_MASK;
            req_pc <= '0;
        end else if (redirect) begin
            PC <= nPC & PC_MASK;
            unique case (state)
                // A response arriving with the redirect is consumed here, so nothing is left to drop.
                WAIT:    state <= imemRvalid ? IDLE : DROP;
                DROP:    state <= imemRvalid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_pc <= PC;
                        PC     <= PC + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT:    if (imemRvalid) state <= IDLE;
                DROP:    if (imemRvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect flushes without counting a pop.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[tail] <= imemRdata;
            buf_pc[tail]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a small latency-programmable memory model.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic [31:0] nPC;
    logic        redirect;
    logic        stall;
    logic [31:0] PC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPC;

    ifetch_unit #(.RESET_PC(RST_PC), .IBUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .nPC        (nPC),
        .redirect   (redirect),
        .stall      (stall),
        .PC         (PC),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instValid  (instValid),
        .inst       (inst),
        .instPC     (instPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass   = 0;
    int          n_checks = 0;
    int          n_deliv  = 0;
    int          lat      = 1;
    int          pcnt     = 0;
    bit          pend     = 0;
    bit          last_acc = 0;
    logic [31:0] paddr;
    logic [31:0] exp_fetch;
    logic [31:0] exp_deliv;
    logic [31:0] a0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock: check fetch/delivery order before the edge, then drive the memory model.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = (imemReq === 1'b1) && imemReady;
        a   = imemAddr;
        if (acc) begin
            check("fetch_addr", a, exp_fetch);
            exp_fetch += 32'd4;
        end
        if ((instValid === 1'b1) && !stall && !redirect && !rst) begin
            check("inst_pc", instPC, exp_deliv);
            check("inst_word", inst, mem_word(exp_deliv));
            exp_deliv += 32'd4;
            n_deliv++;
        end
        @(posedge clk);
        #1;
        redirect   = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        if (acc) begin
            pend  = 1;
            pcnt  = lat;
            paddr = a;
        end
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                imemRvalid = 1'b1;
                imemRdata  = mem_word(paddr);
                pend       = 0;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect  = 1'b1;
        nPC       = t;
        exp_fetch = t & 32'hFFFF_FFFC;
        exp_deliv = t & 32'hFFFF_FFFC;
        cyc();
    endtask

    task automatic wait_acc(input string tag, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cyc();
            found = last_acc;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit found = (instValid === 1'b1);
        for (int i = 0; i < budget && !found; i++) begin
            cyc();
            found = (instValid === 1'b1);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        rst = 1'b1; nPC = '0; redirect = 1'b0; stall = 1'b0;
        imemReady = 1'b1; imemRvalid = 1'b0; imemRdata = '0;
        exp_fetch = RST_PC; exp_deliv = RST_PC;
        #1;
        cyc(); cyc();
        check("rst_pc", PC, RST_PC);
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_valid", 32'(instValid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_instpc", instPC, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req", 32'(imemReq), 32'd1);
        check("post_rst_addr", imemAddr, RST_PC);

        // Sequential fetch, then throughput of one instruction per two cycles.
        for (int i = 0; i < 6; i++) cyc();
        n_deliv = 0;
        for (int i = 0; i < 20; i++) cyc();
        check("throughput", 32'(n_deliv), 32'd10);

        // Stall fills the FIFO and holds the head; release drains in order.
        stall = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("stall_req", 32'(imemReq), 32'd0);
        check("stall_valid", 32'(instValid), 32'd1);
        check("stall_head", instPC, exp_deliv);
        cyc();
        check("stall_hold_pc", instPC, exp_deliv);
        check("stall_hold_inst", inst, mem_word(exp_deliv));
        stall = 1'b0;
        for (int i = 0; i < 10; i++) cyc();

        // Redirect while a fetch is outstanding.
        lat = 2;
        wait_acc("t3_acc", 10);
        do_redirect(32'h0040_0100);
        check("t3_valid", 32'(instValid), 32'd0);
        check("t3_drop_req", 32'(imemReq), 32'd0);
        cyc();
        check("t3_req", 32'(imemReq), 32'd1);
        check("t3_addr", imemAddr, 32'h0040_0100);
        wait_valid("t3_wait", 10);
        check("t3_first", instPC, 32'h0040_0100);

        // Redirect in DROP coinciding with the stale response.
        lat = 3;
        wait_acc("t4_acc", 10);
        do_redirect(32'h0040_0180);
        check("t4_drop_req", 32'(imemReq), 32'd0);
        cyc();
        check("t4_still_drop", 32'(imemReq), 32'd0);
        check("t4_rvalid", 32'(imemRvalid), 32'd1);
        do_redirect(32'h0040_0200);
        check("t4_req", 32'(imemReq), 32'd1);
        check("t4_addr", imemAddr, 32'h0040_0200);
        check("t4_valid", 32'(instValid), 32'd0);
        lat = 1;
        wait_valid("t4_wait", 10);
        check("t4_first", instPC, 32'h0040_0200);

        // Back-pressure from memory, misaligned redirect, PC wrap.
        for (int i = 0; i < 10 && (imemReq !== 1'b1); i++) cyc();
        a0 = imemAddr;
        imemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_addr_hold", imemAddr, a0);
            check("t5_pc_hold", PC, a0);
            check("t5_req_hold", 32'(imemReq), 32'd1);
        end
        do_redirect(32'h0040_0103);
        check("t5_pc_align", PC, 32'h0040_0100);
        imemReady = 1'b1;
        cyc();
        check("t5_acc", 32'(last_acc), 32'd1);
        cyc();
        do_redirect(32'hFFFF_FFFC);
        wait_acc("t5_wrap_acc", 10);
        check("t5_wrap_pc", PC, 32'h0000_0000);
        for (int i = 0; i < 6; i++) cyc();

        // Reset while WAIT with one entry buffered; late response lands in IDLE.
        stall = 1'b1;
        lat = 3;
        begin
            bit found = 0;
            for (int i = 0; i < 30 && !found; i++) begin
                cyc();
                found = last_acc && (instValid === 1'b1);
            end
            check("t6_setup", 32'(found), 32'd1);
        end
        rst = 1'b1;
        exp_fetch = RST_PC;
        exp_deliv = RST_PC;
        cyc();
        rst = 1'b0;
        imemReady = 1'b0;
        #1;
        check("t6_pc", PC, RST_PC);
        check("t6_valid", 32'(instValid), 32'd0);
        check("t6_req", 32'(imemReq), 32'd1);
        check("t6_addr", imemAddr, RST_PC);
        cyc();
        check("t6_late_rvalid", 32'(imemRvalid), 32'd1);
        cyc();
        check("t6_ignored", 32'(instValid), 32'd0);
        lat = 1;
        stall = 1'b0;
        imemReady = 1'b1;
        wait_valid("t6_wait", 10);
        check("t6_first", instPC, RST_PC);
        for (int i = 0; i < 6; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
